// File: rtl/fetch_pc_queue.sv
// Instruction-fetch front end: sequential PC generation, single-outstanding memory fetch, PC/instruction queue to decode.
// Optional FETCH_ALIGN_CHK_EN: misaligned redirect raises a sticky fault that blocks issue.
module fetch_pc_queue #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        STEP     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [DATA_W-1:0] if_inst_o,
  input  logic              if_ready_i,
  output logic              fault_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   fetch_pc, fetch_pc_n;
  logic [ADDR_W-1:0]   req_pc, req_pc_n;
  logic                discard, discard_n;
  logic                fault_q;
  logic                push, pop;
  logic [ADDR_W-1:0]   redirect_tgt;

  logic [ADDR_W-1:0]   q_pc   [DEPTH];
  logic [DATA_W-1:0]   q_inst [DEPTH];
  logic [CNT_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;

`ifdef FETCH_ALIGN_CHK_EN
  logic fault_n;

  assign redirect_tgt = redirect_pc_i;

  // Sticky until a redirect to an aligned target.
  always_comb begin
    fault_n = fault_q;
    if (redirect_i) fault_n = |redirect_pc_i[1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_n;
  end
`else
  assign redirect_tgt = redirect_pc_i & ~ADDR_W'(3);
  assign fault_q      = 1'b0;
`endif

  assign fault_o = fault_q;

  // Next-state, PC bookkeeping and queue push/pop decisions.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req_pc_n   = req_pc;
    discard_n  = discard;
    push       = 1'b0;
    pop        = if_valid_o && if_ready_i && !redirect_i;
    unique case (state)
      IDLE: begin
        if (!stall_i && !redirect_i && (count < CNT_W'(DEPTH)) && !fault_q) begin
          state_n  = REQ;
          req_pc_n = fetch_pc;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          state_n = WAIT;
          if (!redirect_i && !discard) fetch_pc_n = fetch_pc + ADDR_W'(STEP);
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          state_n   = IDLE;
          push      = !discard && !redirect_i;
          discard_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
    // A response retiring in the redirect cycle needs no discard.
    if (redirect_i) begin
      fetch_pc_n = redirect_tgt;
      if ((state == REQ) || ((state == WAIT) && !mem_rvalid_i)) discard_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      discard  <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      req_pc   <= req_pc_n;
      discard  <= discard_n;
    end
  end

  // PC/instruction queue; redirect flush takes priority over push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else if (redirect_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_pc[wr_ptr[PTR_W-1:0]]   <= req_pc;
        q_inst[wr_ptr[PTR_W-1:0]] <= mem_rdata_i;
        wr_ptr                    <= wr_ptr + CNT_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + CNT_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign mem_req_o  = (state == REQ);
  assign mem_addr_o = req_pc;
  assign if_valid_o = (wr_ptr != rd_ptr);
  assign if_pc_o    = q_pc[rd_ptr[PTR_W-1:0]];
  assign if_inst_o  = q_inst[rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Directed bench for fetch_pc_queue with a small memory responder (configurable grant/response latency).
module tb_fetch_pc_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_ready_i = 1'b0;
  logic        fault_o;

  int n_checks = 0;
  int n_errors = 0;

  // responder controls and log
  bit          mem_auto = 0;
  bit          force_rv = 0;
  int          gnt_delay = 0;
  int          rv_delay = 0;
  int          gnt_wait = 0;
  int          rv_wait = 0;
  bit          rv_pend = 0;
  logic [31:0] rv_addr = '0;
  int          cyc = 0;
  logic [31:0] gnt_addr[$];
  int          gnt_cyc[$];

  fetch_pc_queue #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0), .STEP(4)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
    .if_ready_i(if_ready_i), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Memory model: grant after gnt_delay cycles of request, respond rv_delay cycles after the WAIT entry.
  always @(posedge clk) begin
    #1;
    cyc++;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = force_rv;
    if (force_rv) mem_rdata_i = 32'h1234_5678;
    if (rst) begin
      rv_pend  = 0;
      rv_wait  = 0;
      gnt_wait = 0;
    end else if (rv_pend) begin
      if (rv_wait == rv_delay) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = inst_of(rv_addr);
        rv_pend      = 0;
        rv_wait      = 0;
      end else rv_wait++;
    end else if (mem_auto && mem_req_o) begin
      if (gnt_wait == gnt_delay) begin
        mem_gnt_i = 1'b1;
        rv_pend   = 1;
        rv_addr   = mem_addr_o;
        gnt_wait  = 0;
        gnt_addr.push_back(mem_addr_o);
        gnt_cyc.push_back(cyc);
      end else gnt_wait++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input bit hold_stall);
    rst = 1; redirect_i = 0; if_ready_i = 0; stall_i = hold_stall;
    mem_auto = 0; force_rv = 0; gnt_delay = 0; rv_delay = 0;
    step(); step();
    gnt_addr.delete(); gnt_cyc.delete();
    rst = 0;
  endtask

  task automatic wait_gnt(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (gnt_addr.size() >= n) ok = 1;
      else step();
    end
    if (gnt_addr.size() >= n) ok = 1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (if_valid_o) ok = 1;
      else step();
    end
    if (if_valid_o) ok = 1;
  endtask

  task automatic test_reset();
    rst = 1;
    step(); step();
    n_checks++;
    if ({mem_req_o, mem_addr_o, if_valid_o, if_pc_o, if_inst_o, fault_o} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_outputs: got req=%b addr=%h v=%b pc=%h inst=%h f=%b expected all zero",
               mem_req_o, mem_addr_o, if_valid_o, if_pc_o, if_inst_o, fault_o);
    end
    rst = 0;
    step();
    n_checks++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0}) begin
      n_errors++;
      $display("FAIL first_req: got req=%b addr=%h expected 1/00000000", mem_req_o, mem_addr_o);
    end
  endtask

  task automatic test_sequential();
    bit ok;
    do_reset(0);
    mem_auto = 1;
    wait_gnt(3, 40, ok);
    stall_i = 1;
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL seq_timeout: got %0d grants expected 3", gnt_addr.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (gnt_addr[i] !== 32'(4 * i)) begin
        n_errors++;
        $display("FAIL seq_addr%0d: got %h expected %h", i, gnt_addr[i], 32'(4 * i));
      end
    end
    n_checks++;
    if ((gnt_cyc[1] - gnt_cyc[0] != 3) || (gnt_cyc[2] - gnt_cyc[1] != 3)) begin
      n_errors++;
      $display("FAIL seq_rate: got spacing %0d,%0d expected 3,3", gnt_cyc[1] - gnt_cyc[0], gnt_cyc[2] - gnt_cyc[1]);
    end
    step(); step(); step();
    if_ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'(4 * i), inst_of(32'(4 * i))}) begin
        n_errors++;
        $display("FAIL seq_head%0d: got v=%b pc=%h inst=%h expected 1/%h/%h",
                 i, if_valid_o, if_pc_o, if_inst_o, 32'(4 * i), inst_of(32'(4 * i)));
      end
      step();
    end
    n_checks++;
    if (if_valid_o !== 1'b0) begin n_errors++; $display("FAIL seq_drained: got v=%b expected 0", if_valid_o); end
    if_ready_i = 0;
    stall_i = 0;
  endtask

  task automatic test_full();
    bit ok;
    do_reset(0);
    mem_auto = 1;
    wait_gnt(4, 60, ok);
    for (int i = 0; i < 8; i++) step();
    n_checks++;
    if ({ok, 32'(gnt_addr.size()), mem_req_o, if_valid_o, if_pc_o} !== {1'b1, 32'd4, 1'b0, 1'b1, 32'h0}) begin
      n_errors++;
      $display("FAIL full_credit: got grants=%0d req=%b v=%b pc=%h expected 4/0/1/0", gnt_addr.size(), mem_req_o, if_valid_o, if_pc_o);
    end
    if_ready_i = 1;
    step();
    if_ready_i = 0;
    n_checks++;
    if (if_pc_o !== 32'h4) begin n_errors++; $display("FAIL full_pop: got pc=%h expected 00000004", if_pc_o); end
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if ({32'(gnt_addr.size()), mem_req_o, gnt_addr[4]} !== {32'd5, 1'b0, 32'h10}) begin
      n_errors++;
      $display("FAIL full_refill: got grants=%0d req=%b addr4=%h expected 5/0/00000010", gnt_addr.size(), mem_req_o, gnt_addr[4]);
    end
    redirect_i = 1; redirect_pc_i = 32'h40;
    step();
    redirect_i = 0;
    n_checks++;
    if ({if_valid_o, mem_req_o} !== 2'b00) begin
      n_errors++;
      $display("FAIL full_flush: got v=%b req=%b expected 0/0", if_valid_o, mem_req_o);
    end
    step();
    n_checks++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h40}) begin
      n_errors++;
      $display("FAIL full_resume: got req=%b addr=%h expected 1/00000040", mem_req_o, mem_addr_o);
    end
  endtask

  task automatic test_gnt_delay();
    bit ok;
    do_reset(0);
    gnt_delay = 3;
    mem_auto = 1;
    step();
    for (int i = 0; i < 10 && gnt_addr.size() == 0; i++) begin
      n_checks++;
      if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0}) begin
        n_errors++;
        $display("FAIL gd_stable%0d: got req=%b addr=%h expected 1/00000000", i, mem_req_o, mem_addr_o);
      end
      step();
    end
    wait_gnt(2, 30, ok);
    n_checks++;
    if ({ok, gnt_addr[0], gnt_addr[1]} !== {1'b1, 32'h0, 32'h4}) begin
      n_errors++;
      $display("FAIL gd_addrs: got ok=%b %h %h expected 1/00000000/00000004", ok, gnt_addr[0], gnt_addr[1]);
    end
    n_checks++;
    if (gnt_cyc[1] - gnt_cyc[0] != 6) begin
      n_errors++;
      $display("FAIL gd_spacing: got %0d expected 6", gnt_cyc[1] - gnt_cyc[0]);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    do_reset(0);
    rv_delay = 2;
    mem_auto = 1;
    wait_gnt(4, 80, ok);
    step();
    n_checks++;
    if ({ok, if_valid_o, if_pc_o} !== {1'b1, 1'b1, 32'h0}) begin
      n_errors++;
      $display("FAIL rw_pre: got ok=%b v=%b pc=%h expected 1/1/00000000", ok, if_valid_o, if_pc_o);
    end
    redirect_i = 1; redirect_pc_i = 32'h100;
    step();
    redirect_i = 0;
    n_checks++;
    if (if_valid_o !== 1'b0) begin n_errors++; $display("FAIL rw_flush: got v=%b expected 0", if_valid_o); end
    step(); step();
    n_checks++;
    if ({if_valid_o, mem_req_o} !== 2'b00) begin
      n_errors++;
      $display("FAIL rw_stale_drop: got v=%b req=%b expected 0/0", if_valid_o, mem_req_o);
    end
    wait_gnt(5, 20, ok);
    n_checks++;
    if ({ok, gnt_addr[4]} !== {1'b1, 32'h100}) begin
      n_errors++;
      $display("FAIL rw_target: got ok=%b addr=%h expected 1/00000100", ok, gnt_addr[4]);
    end
    wait_valid(20, ok);
    n_checks++;
    if ({ok, if_pc_o, if_inst_o} !== {1'b1, 32'h100, inst_of(32'h100)}) begin
      n_errors++;
      $display("FAIL rw_first_word: got ok=%b pc=%h inst=%h expected 1/00000100/%h", ok, if_pc_o, if_inst_o, inst_of(32'h100));
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset(0);
    mem_auto = 1;
    wait_gnt(2, 30, ok);
    step();
    redirect_i = 1; redirect_pc_i = 32'h80; if_ready_i = 1;
    step();
    redirect_i = 0; if_ready_i = 0;
    n_checks++;
    if ({ok, if_valid_o, mem_req_o} !== {1'b1, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL bb_flush: got ok=%b v=%b req=%b expected 1/0/0", ok, if_valid_o, mem_req_o);
    end
    step();
    n_checks++;
    if ({mem_req_o, mem_addr_o, if_valid_o} !== {1'b1, 32'h80, 1'b0}) begin
      n_errors++;
      $display("FAIL bb_target: got req=%b addr=%h v=%b expected 1/00000080/0", mem_req_o, mem_addr_o, if_valid_o);
    end
    wait_valid(20, ok);
    n_checks++;
    if ({ok, if_pc_o, if_inst_o} !== {1'b1, 32'h80, inst_of(32'h80)}) begin
      n_errors++;
      $display("FAIL bb_word: got ok=%b pc=%h inst=%h expected 1/00000080/%h", ok, if_pc_o, if_inst_o, inst_of(32'h80));
    end
  endtask

  task automatic test_align();
    do_reset(1);
    step();
    redirect_i = 1; redirect_pc_i = 32'h102;
    step();
    redirect_i = 0; stall_i = 0; mem_auto = 1;
`ifdef FETCH_ALIGN_CHK_EN
    n_checks++;
    if (fault_o !== 1'b1) begin n_errors++; $display("FAIL al_fault_set: got %b expected 1", fault_o); end
    for (int i = 0; i < 6; i++) step();
    n_checks++;
    if ({mem_req_o, 32'(gnt_addr.size())} !== {1'b0, 32'd0}) begin
      n_errors++;
      $display("FAIL al_blocked: got req=%b grants=%0d expected 0/0", mem_req_o, gnt_addr.size());
    end
    redirect_i = 1; redirect_pc_i = 32'h200;
    step();
    redirect_i = 0;
    n_checks++;
    if (fault_o !== 1'b0) begin n_errors++; $display("FAIL al_fault_clr: got %b expected 0", fault_o); end
    step();
    n_checks++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h200}) begin
      n_errors++;
      $display("FAIL al_resume: got req=%b addr=%h expected 1/00000200", mem_req_o, mem_addr_o);
    end
`else
    n_checks++;
    if (fault_o !== 1'b0) begin n_errors++; $display("FAIL al_no_fault: got %b expected 0", fault_o); end
    step();
    n_checks++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h100}) begin
      n_errors++;
      $display("FAIL al_masked: got req=%b addr=%h expected 1/00000100", mem_req_o, mem_addr_o);
    end
`endif
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset(1);
    step();
    redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 0; stall_i = 0; mem_auto = 1;
    wait_gnt(2, 30, ok);
    n_checks++;
    if ({ok, gnt_addr[0], gnt_addr[1]} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
      n_errors++;
      $display("FAIL wrap: got ok=%b %h %h expected 1/fffffffc/00000000", ok, gnt_addr[0], gnt_addr[1]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset(0);
    rv_delay = 3;
    mem_auto = 1;
    wait_gnt(1, 20, ok);
    step();
    rst = 1;
    step();
    n_checks++;
    if ({ok, mem_req_o, mem_addr_o, if_valid_o} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_errors++;
      $display("FAIL rm_reset: got ok=%b req=%b addr=%h v=%b expected 1/0/00000000/0", ok, mem_req_o, mem_addr_o, if_valid_o);
    end
    stall_i = 1; rst = 0; mem_auto = 0; force_rv = 1;
    step();
    force_rv = 0;
    step();
    n_checks++;
    if ({if_valid_o, mem_req_o} !== 2'b00) begin
      n_errors++;
      $display("FAIL rm_late_rvalid: got v=%b req=%b expected 0/0", if_valid_o, mem_req_o);
    end
    stall_i = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_full();
    test_gnt_delay();
    test_redirect_wait();
    test_back_to_back();
    test_align();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
